// File: rtl/bp_pkg.sv
// Shared definitions for the fetch-stage branch predictor: opcodes, table entry
// layout, op-class decode values and counter helpers.
package bp_pkg;

  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;

  // Storage ceilings; the module's TAG_BITS/CTR_BITS must not exceed these and
  // only the low TAG_BITS/CTR_BITS bits of each field carry state.
  localparam int MAX_TAG_BITS = 30;
  localparam int MAX_CTR_BITS = 16;

  typedef logic [MAX_CTR_BITS-1:0] ctr_t;

  typedef struct packed {
    logic                    valid;
    logic [MAX_TAG_BITS-1:0] tag;
    ctr_t                    ctr;
  } entry_t;

  typedef enum logic [1:0] {
    CLS_OTHER  = 2'd0,
    CLS_JUMP   = 2'd1,
    CLS_BRANCH = 2'd2
  } op_class_e;

  function automatic ctr_t weak_taken(input int unsigned ctr_bits);
    return ctr_t'(32'd1 << (ctr_bits - 32'd1));
  endfunction

  function automatic ctr_t weak_not_taken(input int unsigned ctr_bits);
    return ctr_t'((32'd1 << (ctr_bits - 32'd1)) - 32'd1);
  endfunction

  function automatic ctr_t sat_update(input ctr_t ctr, input logic up,
                                      input int unsigned ctr_bits);
    ctr_t max_val;
    max_val = ctr_t'((32'd1 << ctr_bits) - 32'd1);
    if (up) return (ctr == max_val) ? ctr : ctr + ctr_t'(1);
    return (ctr == '0) ? ctr : ctr - ctr_t'(1);
  endfunction

endpackage

// File: rtl/target_calc.sv
// Combinational next-PC / jump-target / branch-target and opcode-class decode
// for the instruction currently in fetch.
module target_calc
  import bp_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  output logic [31:0] next_pc,
  output logic [31:0] jta,
  output logic [31:0] bta,
  output op_class_e   op_class,
  output logic        backward
);

  logic [5:0]  opcode;
  logic [15:0] imm;

  assign opcode   = instr[31:26];
  assign imm      = instr[15:0];
  assign next_pc  = pc + 32'd4;
  assign jta      = {next_pc[31:28], instr[25:0], 2'b00};
  assign bta      = next_pc + {{14{imm[15]}}, imm, 2'b00};
  assign backward = imm[15];

  always_comb begin
    op_class = CLS_OTHER;
    case (opcode)
      OP_J, OP_JAL:     op_class = CLS_JUMP;
      OP_BEQ, OP_BNE:   op_class = CLS_BRANCH;
      default:          op_class = CLS_OTHER;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic BEQ/BNE predictor with tagged saturating-counter table, static
// backward-taken fallback, execute-stage training and accuracy statistics.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 8,
  parameter int CTR_BITS   = 2,
  parameter int STAT_W     = 32,
  parameter int DYNAMIC    = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [31:0]       fetch_pc,
  input  logic [31:0]       fetch_instr,
  output logic [31:0]       pred_pc,
  output logic              pred_taken,
  input  logic              upd_valid,
  input  logic [31:0]       upd_pc,
  input  logic              upd_taken,
  input  logic              upd_mispredict,
  output logic [STAT_W-1:0] branch_count,
  output logic [STAT_W-1:0] mispredict_count
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam entry_t RESET_ENTRY = '{valid: 1'b0, tag: '0,
                                     ctr: weak_not_taken(CTR_BITS)};

  entry_t entry_q [ENTRIES];
  entry_t entry_d [ENTRIES];

  logic [STAT_W-1:0] branch_count_q, branch_count_d;
  logic [STAT_W-1:0] mispredict_count_q, mispredict_count_d;

  logic [INDEX_BITS-1:0] fetch_idx, upd_idx;
  logic [TAG_BITS-1:0]   fetch_tag, upd_tag;

  logic [31:0] next_pc, jta, bta;
  op_class_e   op_class;
  logic        backward;

  logic   fetch_hit, upd_hit, branch_taken;
  entry_t new_entry;
  logic   unused_upd_pc;

  assign fetch_idx = fetch_pc[INDEX_BITS+1:2];
  assign fetch_tag = fetch_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
  assign upd_idx   = upd_pc[INDEX_BITS+1:2];
  assign upd_tag   = upd_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
  assign unused_upd_pc = ^upd_pc;

  target_calc u_target_calc (
    .pc       (fetch_pc),
    .instr    (fetch_instr),
    .next_pc  (next_pc),
    .jta      (jta),
    .bta      (bta),
    .op_class (op_class),
    .backward (backward)
  );

  // Lookup reads registered state only, so a same-cycle update is not bypassed.
  assign fetch_hit = (DYNAMIC != 0) && entry_q[fetch_idx].valid &&
                     (entry_q[fetch_idx].tag[TAG_BITS-1:0] == fetch_tag);
  assign branch_taken = fetch_hit ? entry_q[fetch_idx].ctr[CTR_BITS-1] : backward;

  always_comb begin
    pred_pc    = next_pc;
    pred_taken = 1'b0;
    case (op_class)
      CLS_JUMP: begin
        pred_pc    = jta;
        pred_taken = 1'b1;
      end
      CLS_BRANCH: begin
        pred_taken = branch_taken;
        pred_pc    = branch_taken ? bta : next_pc;
      end
      default: begin
        pred_pc    = next_pc;
        pred_taken = 1'b0;
      end
    endcase
  end

  assign upd_hit = entry_q[upd_idx].valid &&
                   (entry_q[upd_idx].tag[TAG_BITS-1:0] == upd_tag);

  always_comb begin
    new_entry = '0;
    if (upd_hit) begin
      new_entry = entry_q[upd_idx];
      new_entry.ctr = sat_update(entry_q[upd_idx].ctr, upd_taken, CTR_BITS);
    end else begin
      new_entry.valid = 1'b1;
      new_entry.tag[TAG_BITS-1:0] = upd_tag;
      new_entry.ctr = upd_taken ? weak_taken(CTR_BITS) : weak_not_taken(CTR_BITS);
    end
  end

  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
    always_comb begin
      entry_d[gi] = entry_q[gi];
      if (upd_valid && (upd_idx == INDEX_BITS'(gi))) entry_d[gi] = new_entry;
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) entry_q[gi] <= RESET_ENTRY;
      else         entry_q[gi] <= entry_d[gi];
    end
  end

  // Statistics stick at all-ones rather than wrapping.
  always_comb begin
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (upd_valid) begin
      if (branch_count_q != '1) branch_count_d = branch_count_q + 1'b1;
      if (upd_mispredict && (mispredict_count_q != '1))
        mispredict_count_d = mispredict_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench: default predictor, a 4-bit-statistics variant
// and a static-only variant all driven with the same stimulus.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] fetch_pc, fetch_instr, upd_pc;
  logic        upd_valid, upd_taken, upd_mispredict;

  logic [31:0] pred_pc, pred_pc_s, pred_pc_st;
  logic        pred_taken, pred_taken_s, pred_taken_st;
  logic [31:0] bc, mc, bc_st, mc_st;
  logic [3:0]  bc_s, mc_s;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_br   = 0;
  int exp_mis  = 0;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk(clk), .resetn(resetn), .fetch_pc(fetch_pc), .fetch_instr(fetch_instr),
    .pred_pc(pred_pc), .pred_taken(pred_taken), .upd_valid(upd_valid),
    .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_mispredict(upd_mispredict),
    .branch_count(bc), .mispredict_count(mc)
  );

  branch_predictor #(.STAT_W(4)) dut_s (
    .clk(clk), .resetn(resetn), .fetch_pc(fetch_pc), .fetch_instr(fetch_instr),
    .pred_pc(pred_pc_s), .pred_taken(pred_taken_s), .upd_valid(upd_valid),
    .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_mispredict(upd_mispredict),
    .branch_count(bc_s), .mispredict_count(mc_s)
  );

  branch_predictor #(.DYNAMIC(0)) dut_st (
    .clk(clk), .resetn(resetn), .fetch_pc(fetch_pc), .fetch_instr(fetch_instr),
    .pred_pc(pred_pc_st), .pred_taken(pred_taken_st), .upd_valid(upd_valid),
    .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_mispredict(upd_mispredict),
    .branch_count(bc_st), .mispredict_count(mc_st)
  );

  function automatic logic [31:0] br(input logic [5:0] op, input logic [15:0] imm);
    return {op, 10'd0, imm};
  endfunction

  function automatic logic [31:0] jmp(input logic [5:0] op, input logic [25:0] addr);
    return {op, addr};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_update(input logic [31:0] pc, input logic taken, input logic mis);
    upd_pc = pc; upd_taken = taken; upd_mispredict = mis; upd_valid = 1'b1;
    tick();
    upd_valid = 1'b0; upd_mispredict = 1'b0;
    exp_br++;
    if (mis) exp_mis++;
    $display("update pc=%08h taken=%0b mispredict=%0b -> branch_count=%0d mispredict_count=%0d",
             pc, taken, mis, bc, mc);
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] instr);
    fetch_pc = pc; fetch_instr = instr;
    #1;
  endtask

  task automatic test_reset();
    fetch(32'h0000_0100, 32'h0);
    n_checks++; if (pred_pc !== 32'h0000_0104 || pred_taken !== 1'b0) begin n_fail++;
      $display("FAIL reset_other: got pc=%08h t=%0b want 00000104/0", pred_pc, pred_taken); end
    n_checks++; if (bc !== 32'd0 || mc !== 32'd0 || bc_s !== 4'd0 || mc_s !== 4'd0) begin n_fail++;
      $display("FAIL reset_counts: got %0d/%0d %0d/%0d want 0", bc, mc, bc_s, mc_s); end
    fetch(32'h0000_0040, br(6'h04, 16'hFFFE));
    n_checks++; if (pred_pc !== 32'h0000_003C || pred_taken !== 1'b1) begin n_fail++;
      $display("FAIL reset_static: got pc=%08h t=%0b want 0000003c/1", pred_pc, pred_taken); end
    upd_pc = 32'h0000_0040; upd_taken = 1'b0; upd_mispredict = 1'b1; upd_valid = 1'b1;
    tick();
    upd_valid = 1'b0; upd_mispredict = 1'b0;
    n_checks++; if (bc !== 32'd0 || mc !== 32'd0) begin n_fail++;
      $display("FAIL reset_update_dropped: got %0d/%0d want 0/0", bc, mc); end
    resetn = 1'b1;
    $display("reset released");
  endtask

  task automatic test_static();
    fetch(32'h0000_0040, br(6'h04, 16'hFFFE));
    n_checks++; if (pred_pc !== 32'h0000_003C || pred_taken !== 1'b1) begin n_fail++;
      $display("FAIL static_backward: got pc=%08h t=%0b want 0000003c/1", pred_pc, pred_taken); end
    fetch(32'h0000_0040, br(6'h04, 16'h0003));
    n_checks++; if (pred_pc !== 32'h0000_0044 || pred_taken !== 1'b0) begin n_fail++;
      $display("FAIL static_forward: got pc=%08h t=%0b want 00000044/0", pred_pc, pred_taken); end
    fetch(32'h0000_0000, br(6'h05, 16'hFFFE));
    n_checks++; if (pred_pc !== 32'hFFFF_FFFC || pred_taken !== 1'b1) begin n_fail++;
      $display("FAIL static_bta_wrap: got pc=%08h t=%0b want fffffffc/1", pred_pc, pred_taken); end
    fetch(32'hFFFF_FFFC, jmp(6'h02, 26'h0000010));
    n_checks++; if (pred_pc !== 32'h0000_0040 || pred_taken !== 1'b1) begin n_fail++;
      $display("FAIL jump_wrap: got pc=%08h t=%0b want 00000040/1", pred_pc, pred_taken); end
    fetch(32'h2000_0010, jmp(6'h02, 26'h3FF_FFFF));
    n_checks++; if (pred_pc !== 32'h2FFF_FFFC || pred_taken !== 1'b1) begin n_fail++;
      $display("FAIL jump_region: got pc=%08h t=%0b want 2ffffffc/1", pred_pc, pred_taken); end
  endtask

  task automatic test_train();
    do_update(32'h0000_0080, 1'b1, 1'b1);
    fetch(32'h0000_0080, br(6'h04, 16'h0004));
    n_checks++; if (pred_pc !== 32'h0000_0094 || pred_taken !== 1'b1) begin n_fail++;
      $display("FAIL train_alloc_taken: got pc=%08h t=%0b want 00000094/1", pred_pc, pred_taken); end
    n_checks++; if (pred_pc_st !== 32'h0000_0084 || pred_taken_st !== 1'b0) begin n_fail++;
      $display("FAIL static_ignores_table: got pc=%08h t=%0b want 00000084/0", pred_pc_st, pred_taken_st); end
    do_update(32'h0000_0080, 1'b0, 1'b0);
    do_update(32'h0000_0080, 1'b0, 1'b0);
    #1;
    n_checks++; if (pred_pc !== 32'h0000_0084 || pred_taken !== 1'b0) begin n_fail++;
      $display("FAIL train_not_taken: got pc=%08h t=%0b want 00000084/0", pred_pc, pred_taken); end
    for (int i = 0; i < 3; i++) do_update(32'h0000_0080, 1'b1, 1'b0);
    #1;
    n_checks++; if (pred_taken !== 1'b1) begin n_fail++;
      $display("FAIL train_ctr3: got t=%0b want 1", pred_taken); end
    do_update(32'h0000_0080, 1'b1, 1'b0);
    #1;
    n_checks++; if (pred_taken !== 1'b1) begin n_fail++;
      $display("FAIL train_saturate_high: got t=%0b want 1", pred_taken); end
    do_update(32'h0000_0080, 1'b0, 1'b0);
    #1;
    n_checks++; if (pred_taken !== 1'b1 || pred_pc !== 32'h0000_0094) begin n_fail++;
      $display("FAIL train_hysteresis: got pc=%08h t=%0b want 00000094/1", pred_pc, pred_taken); end
    do_update(32'h0000_0080, 1'b0, 1'b0);
    #1;
    n_checks++; if (pred_taken !== 1'b0) begin n_fail++;
      $display("FAIL train_second_nt: got t=%0b want 0", pred_taken); end
    n_checks++; if (bc !== 32'(exp_br) || mc !== 32'(exp_mis)) begin n_fail++;
      $display("FAIL train_counts: got %0d/%0d want %0d/%0d", bc, mc, exp_br, exp_mis); end
  endtask

  task automatic test_alias();
    do_update(32'h0000_0080, 1'b1, 1'b0);
    do_update(32'h0000_0180, 1'b0, 1'b0);
    fetch(32'h0000_0080, br(6'h04, 16'hFFFE));
    n_checks++; if (pred_pc !== 32'h0000_007C || pred_taken !== 1'b1) begin n_fail++;
      $display("FAIL alias_evicted_static: got pc=%08h t=%0b want 0000007c/1", pred_pc, pred_taken); end
    fetch(32'h0000_0180, br(6'h04, 16'hFFFE));
    n_checks++; if (pred_pc !== 32'h0000_0184 || pred_taken !== 1'b0) begin n_fail++;
      $display("FAIL alias_new_owner: got pc=%08h t=%0b want 00000184/0", pred_pc, pred_taken); end
  endtask

  task automatic test_same_cycle();
    fetch(32'h0000_0180, br(6'h04, 16'hFFFE));
    upd_pc = 32'h0000_0180; upd_taken = 1'b1; upd_mispredict = 1'b0; upd_valid = 1'b1;
    #1;
    n_checks++; if (pred_taken !== 1'b0) begin n_fail++;
      $display("FAIL same_cycle_old: got t=%0b want 0", pred_taken); end
    tick();
    upd_valid = 1'b0;
    exp_br++;
    $display("update pc=00000180 taken=1 (same-cycle lookup)");
    n_checks++; if (pred_pc !== 32'h0000_017C || pred_taken !== 1'b1) begin n_fail++;
      $display("FAIL same_cycle_new: got pc=%08h t=%0b want 0000017c/1", pred_pc, pred_taken); end
  endtask

  task automatic test_reset_mid();
    fetch(32'h0000_0180, br(6'h04, 16'h0004));
    n_checks++; if (pred_pc !== 32'h0000_0194 || pred_taken !== 1'b1) begin n_fail++;
      $display("FAIL premid_hit: got pc=%08h t=%0b want 00000194/1", pred_pc, pred_taken); end
    upd_pc = 32'h0000_0180; upd_taken = 1'b1; upd_mispredict = 1'b1; upd_valid = 1'b1;
    #2 resetn = 1'b0;
    #1;
    n_checks++; if (bc !== 32'd0 || mc !== 32'd0 || bc_s !== 4'd0) begin n_fail++;
      $display("FAIL midreset_counts: got %0d/%0d/%0d want 0", bc, mc, bc_s); end
    n_checks++; if (pred_pc !== 32'h0000_0184 || pred_taken !== 1'b0) begin n_fail++;
      $display("FAIL midreset_table: got pc=%08h t=%0b want 00000184/0", pred_pc, pred_taken); end
    tick();
    n_checks++; if (bc !== 32'd0 || mc !== 32'd0) begin n_fail++;
      $display("FAIL midreset_update_dropped: got %0d/%0d want 0/0", bc, mc); end
    upd_valid = 1'b0; upd_mispredict = 1'b0;
    resetn = 1'b1;
    exp_br = 0; exp_mis = 0;
    $display("mid-sequence reset applied and released");
    do_update(32'h0000_0180, 1'b1, 1'b0);
    #1;
    n_checks++; if (bc !== 32'd1 || pred_taken !== 1'b1 || pred_pc !== 32'h0000_0194) begin n_fail++;
      $display("FAIL post_reset_first: got bc=%0d pc=%08h t=%0b want 1/00000194/1", bc, pred_pc, pred_taken); end
  endtask

  task automatic test_stat_sat();
    for (int i = 0; i < 14; i++) do_update(32'h0000_0300, 1'b1, 1'b1);
    n_checks++; if (bc_s !== 4'd15 || mc_s !== 4'd14) begin n_fail++;
      $display("FAIL stat_before_sat: got %0d/%0d want 15/14", bc_s, mc_s); end
    for (int i = 0; i < 6; i++) do_update(32'h0000_0300, 1'b1, 1'b1);
    n_checks++; if (bc_s !== 4'd15 || mc_s !== 4'd15) begin n_fail++;
      $display("FAIL stat_saturated: got %0d/%0d want 15/15", bc_s, mc_s); end
    n_checks++; if (bc !== 32'd21 || mc !== 32'd20) begin n_fail++;
      $display("FAIL stat_wide: got %0d/%0d want 21/20", bc, mc); end
  endtask

  task automatic test_static_persist();
    for (int i = 0; i < 3; i++) do_update(32'h0000_0200, 1'b1, 1'b0);
    fetch(32'h0000_0200, br(6'h05, 16'h0004));
    n_checks++; if (pred_pc !== 32'h0000_0214 || pred_taken !== 1'b1) begin n_fail++;
      $display("FAIL dyn_bne_taken: got pc=%08h t=%0b want 00000214/1", pred_pc, pred_taken); end
    n_checks++; if (pred_pc_st !== 32'h0000_0204 || pred_taken_st !== 1'b0) begin n_fail++;
      $display("FAIL static_fwd_persist: got pc=%08h t=%0b want 00000204/0", pred_pc_st, pred_taken_st); end
    do_update(32'h0000_0240, 1'b0, 1'b0);
    do_update(32'h0000_0240, 1'b0, 1'b0);
    fetch(32'h0000_0240, br(6'h04, 16'hFFFE));
    n_checks++; if (pred_pc !== 32'h0000_0244 || pred_taken !== 1'b0) begin n_fail++;
      $display("FAIL dyn_backward_nt: got pc=%08h t=%0b want 00000244/0", pred_pc, pred_taken); end
    n_checks++; if (pred_pc_st !== 32'h0000_023C || pred_taken_st !== 1'b1) begin n_fail++;
      $display("FAIL static_bwd_persist: got pc=%08h t=%0b want 0000023c/1", pred_pc_st, pred_taken_st); end
  endtask

  task automatic test_jump();
    do_update(32'h1000_0000, 1'b0, 1'b0);
    do_update(32'h1000_0000, 1'b0, 1'b0);
    fetch(32'h1000_0000, jmp(6'h03, 26'h0000100));
    n_checks++; if (pred_pc !== 32'h1000_0400 || pred_taken !== 1'b1) begin n_fail++;
      $display("FAIL jal_target: got pc=%08h t=%0b want 10000400/1", pred_pc, pred_taken); end
    n_checks++; if (pred_pc_st !== 32'h1000_0400 || pred_taken_st !== 1'b1) begin n_fail++;
      $display("FAIL jal_target_static: got pc=%08h t=%0b want 10000400/1", pred_pc_st, pred_taken_st); end
  endtask

  initial begin
    resetn = 1'b0;
    fetch_pc = '0; fetch_instr = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_mispredict = 1'b0;
    tick();
    tick();
    test_reset();
    test_static();
    test_train();
    test_alias();
    test_same_cycle();
    test_reset_mid();
    test_stat_sat();
    test_static_persist();
    test_jump();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised dynamic branch predictor for the fetch stage of the pipelined MIPS core. It computes the next-PC guess for the instruction being fetched:
- J/JAL always redirect to their jump target.
- BEQ/BNE are predicted taken or not-taken from a tagged table of saturating counters, falling back to static backward-taken/forward-not-taken on a table miss.
- The table is trained from the execute stage, and saturating statistics counters expose predictor accuracy.

## Interface

Parameters:
- INDEX_BITS, 6, log2 of table entries (64 entries)
- TAG_BITS, 8, stored tag width; INDEX_BITS+TAG_BITS <= 30
- CTR_BITS, 2, saturating-counter width, >= 1
- STAT_W, 32, width of statistics counters
- DYNAMIC, 1, 1 = table prediction; 0 = static prediction only (table never consulted, still trained)

Ports:
- clk  in  1  system clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- fetch_pc  in  32  PC of instruction in fetch
- fetch_instr  in  32  instruction word in fetch
- pred_pc  out  32  predicted next PC (combinational)
- pred_taken  out  1  1 when pred_pc is a redirect (jump, or branch predicted taken)
- upd_valid  in  1  execute stage resolved a BEQ/BNE this cycle
- upd_pc  in  32  PC of resolved branch
- upd_taken  in  1  actual branch outcome
- upd_mispredict  in  1  the prediction made for this branch was wrong; qualified by upd_valid
- branch_count  out  STAT_W  resolved branches since reset
- mispredict_count  out  STAT_W  mispredicted branches since reset

## Operation

- next_pc = fetch_pc+4; jta = {next_pc[31:28], instr[25:0], 2'b00}; bta = next_pc + (sign-extended imm16 << 2), all mod 2^32.
- Index = pc[INDEX_BITS+1:2]; tag = pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2]. Each entry holds valid, tag and CTR_BITS counter.
- Prediction:
  - JMP/JAL: pred_pc=jta, pred_taken=1.
  - BEQ/BNE, DYNAMIC=1, entry valid and tag equal: taken iff counter MSB=1.
  - BEQ/BNE otherwise (miss or DYNAMIC=0): taken iff imm16[15]=1 (backward).
  - Taken: pred_pc=bta. Not-taken: pred_pc=next_pc.
  - Any other opcode: pred_pc=next_pc, pred_taken=0.
- Update, when upd_valid=1:
  - Hit (valid and tag match): counter +1 if upd_taken, -1 otherwise, saturating at 0 and 2^CTR_BITS-1.
  - Miss: allocate/overwrite entry; valid=1; tag=upd tag; counter = 2^(CTR_BITS-1) if taken (weakly taken), 2^(CTR_BITS-1)-1 if not (weakly not-taken).
  - branch_count +1; mispredict_count +1 if upd_mispredict. Both saturate at all-ones (no wrap).
- upd_mispredict with upd_valid=0 is ignored.

## Timing

- Prediction path is purely combinational: zero-cycle latency from fetch_pc/fetch_instr/table state.
- Table and statistics update on the rising clk edge when upd_valid=1. Single update per cycle.
- Same-cycle lookup and update of the same index: lookup sees pre-update contents (no bypass). The new value is visible from the next cycle.
- Reset (resetn low, asynchronous, any time including mid-update): all valid bits=0, all counters = 2^(CTR_BITS-1)-1, branch_count=0, mispredict_count=0.
  - During reset pred_pc/pred_taken still follow the static rule (the table reads as all-invalid).
  - An update coinciding with reset assertion is dropped.
- Reset release is synchronised by the system; the first update is accepted on the first edge with resetn=1.

## Structure

- The shared opcode definitions supply JMP/JAL/BEQ/BNE encodings. No new opcodes.
- Package bp_pkg holds:
  - the entry struct typedef (valid, tag, counter, sized by parameters in the module);
  - a saturating increment/decrement function;
  - the weak-taken/weak-not-taken reset constants as functions of CTR_BITS.
- Sub-module target_calc: combinational next_pc/jta/bta/opcode-class decode from pc and instr. The sequential table stays in branch_predictor.

## Test plan

- Reset, then fetch BEQ at 0x0000_0040 with imm 0xFFFE → pred_taken=1, pred_pc=0x0000_003C (static backward). With imm 0x0003 → pred_taken=0, pred_pc=0x0000_0044.
- JAL at 0x1000_0000, addr field 0x0000100 → pred_pc=0x1000_0400, pred_taken=1, regardless of table contents.
- Forward BEQ at 0x0000_0080, imm 0x0004: resolve taken once → next lookup predicts taken, pred_pc=0x0000_0094. Resolve not-taken twice → predicts not-taken. Resolve taken three more times → counter saturates at 3; a single not-taken still predicts taken.
- Aliasing: train 0x0000_0080 taken, then resolve 0x0000_0180 (same index, different tag; INDEX_BITS=6) not-taken → entry replaced. Lookup at 0x0000_0080 misses and uses the static rule.
- Same-cycle lookup and update at one index → old prediction that cycle, new prediction next cycle. Assert resetn mid-sequence → counts read 0 and the table is invalid immediately.
- STAT_W=4: 20 updates, all with upd_mispredict=1 → both counts hold 15. DYNAMIC=0 → trained table is ignored and static predictions persist.
